// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory stage and its store buffer.
package mem_pkg;

    // Storage widths for a buffered store; narrower configurations zero-extend into them.
    localparam int unsigned SB_ADDR_W = 64;
    localparam int unsigned SB_DATA_W = 64;

    // Store sizes, also the [1:0] size field of a load func3.
    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;
    localparam logic [1:0] ST_SD = 2'd3;

    // Load func3 encodings: [1:0] size, [2] zero-extend.
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [1:0]           st_type;
    } sb_entry_t;

    // True for the zero-extending load variants.
    function automatic logic is_unsigned_load(input logic [2:0] func3);
        return (func3 == LD_LBU) || (func3 == LD_LHU) || (func3 == LD_LWU);
    endfunction

endpackage

// File: rtl/load_mux.sv
// Load alignment: selects a byte/half/word/dword from a cache doubleword at a
// byte offset and sign- or zero-extends it.
//   i_rdata  : cache doubleword
//   i_offset : byte offset within the doubleword
//   i_func3  : [1:0] size, [2] zero-extend
//   o_data   : aligned, extended load value (combinational)
module load_mux
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_offset,
    input  logic [2:0]            i_func3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sext;

    // Right-align the addressed bytes, then extend per size.
    always_comb begin
        shifted = i_rdata >> {i_offset, 3'b000};
        sext    = !is_unsigned_load(i_func3);
        o_data  = shifted;
        case (i_func3[1:0])
            ST_SB: o_data = {{(DATA_WIDTH-8){sext & shifted[7]}},   shifted[7:0]};
            ST_SH: o_data = {{(DATA_WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
            ST_SW: o_data = {{(DATA_WIDTH-32){sext & shifted[31]}}, shifted[31:0]};
            default: o_data = shifted;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer FIFO with a doubleword-match comparator over all valid entries.
//   i_push/i_addr/i_data/i_type : enqueue request (ignored when full)
//   i_ready                     : consumer accepts the head entry this cycle
//   i_cmp_dw                    : doubleword index probed for a conflict
//   o_head_*                    : head entry, o_head_valid when non-empty
//   o_full/o_empty              : occupancy flags
//   o_match                     : some valid entry lies in i_cmp_dw
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SB_DEPTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_type,
    input  logic                  i_ready,
    input  logic [ADDR_WIDTH-4:0] i_cmp_dw,
    output logic                  o_head_valid,
    output logic [ADDR_WIDTH-1:0] o_head_addr,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [1:0]            o_head_type,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_match
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        mem_q [SB_DEPTH];
    sb_entry_t        wr_entry;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop;
    logic [PTR_W-1:0] rel;

    assign o_full       = (count_q == CNT_W'(SB_DEPTH));
    assign o_empty      = (count_q == '0);
    assign o_head_valid = !o_empty;
    assign o_head_addr  = ADDR_WIDTH'(mem_q[head_q].addr);
    assign o_head_data  = DATA_WIDTH'(mem_q[head_q].data);
    assign o_head_type  = mem_q[head_q].st_type;

    // A full buffer refuses the push even if the head drains this cycle.
    assign push_ok = i_push && !o_full;
    assign pop     = !o_empty && i_ready;

    // Pointer and occupancy update.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + PTR_W'(1);
        if (pop)     head_d = head_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        wr_entry         = '0;
        wr_entry.addr    = SB_ADDR_W'(i_addr);
        wr_entry.data    = SB_DATA_W'(i_data);
        wr_entry.st_type = i_type;
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[tail_q] <= wr_entry;
    end

    // Entry i is valid when its distance from head is below the count.
    always_comb begin
        o_match = 1'b0;
        rel     = '0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            rel = PTR_W'(i) - head_q;
            if (({1'b0, rel} < count_q) &&
                (mem_q[i].addr[ADDR_WIDTH-1:3] == i_cmp_dw)) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_stage_sb.sv
// Memory stage with store buffer: queues stores and drains them into the data
// cache, services loads directly from the cache (stalling on buffered
// same-doubleword stores or misses), and ends in the memory/writeback register.
//   i_valid..i_result_src : execute-stage instruction
//   o_stall               : hold upstream this cycle (combinational)
//   o_dc_raddr/i_dc_*     : cache read port
//   o_dc_w*/i_dc_ready    : cache write port fed from the buffer head
//   o_sb_empty            : buffer empty
//   o_valid..o_read_data  : writeback register
module memory_stage_sb
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SB_DEPTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    input  logic                  i_mem_we,
    input  logic                  i_mem_re,
    input  logic [2:0]            i_func3,
    input  logic [ADDR_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reg_we,
    input  logic [2:0]            i_result_src,
    output logic                  o_stall,
    output logic [ADDR_WIDTH-1:0] o_dc_raddr,
    input  logic [DATA_WIDTH-1:0] i_dc_rdata,
    input  logic                  i_dc_hit,
    output logic                  o_dc_we,
    output logic [ADDR_WIDTH-1:0] o_dc_waddr,
    output logic [DATA_WIDTH-1:0] o_dc_wdata,
    output logic [1:0]            o_dc_store_type,
    input  logic                  i_dc_ready,
    output logic                  o_sb_empty,
    output logic                  o_valid,
    output logic                  o_reg_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [2:0]            o_result_src,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    logic                  store_req;
    logic                  load_req;
    logic                  sb_full;
    logic                  sb_match;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  valid_q, valid_d;
    logic                  reg_we_q, reg_we_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]            result_src_q, result_src_d;
    logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

    assign store_req  = i_valid && i_mem_we;
    assign load_req   = i_valid && i_mem_re;
    assign o_dc_raddr = i_alu_result;

    store_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SB_DEPTH   (SB_DEPTH)
    ) u_store_buffer (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_push       (store_req),
        .i_addr       (i_alu_result),
        .i_data       (i_write_data),
        .i_type       (i_func3[1:0]),
        .i_ready      (i_dc_ready),
        .i_cmp_dw     (i_alu_result[ADDR_WIDTH-1:3]),
        .o_head_valid (o_dc_we),
        .o_head_addr  (o_dc_waddr),
        .o_head_data  (o_dc_wdata),
        .o_head_type  (o_dc_store_type),
        .o_full       (sb_full),
        .o_empty      (o_sb_empty),
        .o_match      (sb_match)
    );

    load_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_mux (
        .i_rdata  (i_dc_rdata),
        .i_offset (i_alu_result[2:0]),
        .i_func3  (i_func3),
        .o_data   (load_data)
    );

    // Stall on a full buffer, a same-doubleword buffered store, or a load miss.
    // The match sees registered entries only, so a popping entry still blocks.
    always_comb begin
        o_stall = 1'b0;
        if (store_req && sb_full)                o_stall = 1'b1;
        if (load_req && sb_match)                o_stall = 1'b1;
        if (load_req && !sb_match && !i_dc_hit)  o_stall = 1'b1;
    end

    // Writeback register: bubble on stall or empty slot, payload holds.
    always_comb begin
        valid_d      = 1'b0;
        reg_we_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        result_src_d = result_src_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        if (i_valid && !o_stall) begin
            valid_d      = 1'b1;
            reg_we_d     = i_reg_we;
            rd_addr_d    = i_rd_addr;
            result_src_d = i_result_src;
            alu_result_d = DATA_WIDTH'(i_alu_result);
            read_data_d  = load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            valid_q      <= 1'b0;
            reg_we_q     <= 1'b0;
            rd_addr_q    <= '0;
            result_src_q <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_we_q     <= reg_we_d;
            rd_addr_q    <= rd_addr_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_reg_we     = reg_we_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_result_src = result_src_q;
    assign o_alu_result = alu_result_q;
    assign o_read_data  = read_data_q;

endmodule

// File: tb/tb_memory_stage_sb.sv
// Directed bench for memory_stage_sb: reset, store drain, buffer full and wrap,
// load conflict, load extension, miss stall, reset mid-drain.
module tb_memory_stage_sb;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_valid, i_mem_we, i_mem_re;
    logic [2:0]  i_func3;
    logic [63:0] i_alu_result, i_write_data;
    logic [4:0]  i_rd_addr;
    logic        i_reg_we;
    logic [2:0]  i_result_src;
    logic        o_stall;
    logic [63:0] o_dc_raddr;
    logic [63:0] i_dc_rdata;
    logic        i_dc_hit;
    logic        o_dc_we;
    logic [63:0] o_dc_waddr, o_dc_wdata;
    logic [1:0]  o_dc_store_type;
    logic        i_dc_ready;
    logic        o_sb_empty;
    logic        o_valid, o_reg_we;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic [63:0] o_alu_result, o_read_data;

    int checks = 0;
    int errors = 0;

    memory_stage_sb #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .REG_ADDR_W (5),
        .SB_DEPTH   (4)
    ) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_valid         (i_valid),
        .i_mem_we        (i_mem_we),
        .i_mem_re        (i_mem_re),
        .i_func3         (i_func3),
        .i_alu_result    (i_alu_result),
        .i_write_data    (i_write_data),
        .i_rd_addr       (i_rd_addr),
        .i_reg_we        (i_reg_we),
        .i_result_src    (i_result_src),
        .o_stall         (o_stall),
        .o_dc_raddr      (o_dc_raddr),
        .i_dc_rdata      (i_dc_rdata),
        .i_dc_hit        (i_dc_hit),
        .o_dc_we         (o_dc_we),
        .o_dc_waddr      (o_dc_waddr),
        .o_dc_wdata      (o_dc_wdata),
        .o_dc_store_type (o_dc_store_type),
        .i_dc_ready      (i_dc_ready),
        .o_sb_empty      (o_sb_empty),
        .o_valid         (o_valid),
        .o_reg_we        (o_reg_we),
        .o_rd_addr       (o_rd_addr),
        .o_result_src    (o_result_src),
        .o_alu_result    (o_alu_result),
        .o_read_data     (o_read_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_mem_we     = 1'b0;
        i_mem_re     = 1'b0;
        i_func3      = 3'd0;
        i_alu_result = 64'd0;
        i_write_data = 64'd0;
        i_rd_addr    = 5'd0;
        i_reg_we     = 1'b0;
        i_result_src = 3'd0;
    endtask

    task automatic drive_store(input logic [63:0] addr, input logic [63:0] data,
                               input logic [2:0] f3);
        i_valid      = 1'b1;
        i_mem_we     = 1'b1;
        i_mem_re     = 1'b0;
        i_func3      = f3;
        i_alu_result = addr;
        i_write_data = data;
        i_rd_addr    = 5'd0;
        i_reg_we     = 1'b0;
        i_result_src = 3'd0;
    endtask

    task automatic drive_load(input logic [63:0] addr, input logic [2:0] f3,
                              input logic [4:0] rd);
        i_valid      = 1'b1;
        i_mem_we     = 1'b0;
        i_mem_re     = 1'b1;
        i_func3      = f3;
        i_alu_result = addr;
        i_write_data = 64'd0;
        i_rd_addr    = rd;
        i_reg_we     = 1'b1;
        i_result_src = 3'd1;
    endtask

    task automatic test_reset();
        i_arst = 1'b1;
        tick();
        tick();
        i_arst = 1'b0;
        settle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %0b exp 0", o_valid); end
        checks++; if (o_reg_we !== 1'b0) begin errors++; $display("FAIL reset o_reg_we: got %0b exp 0", o_reg_we); end
        checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset o_rd_addr: got %0h exp 0", o_rd_addr); end
        checks++; if (o_result_src !== 3'd0) begin errors++; $display("FAIL reset o_result_src: got %0h exp 0", o_result_src); end
        checks++; if (o_alu_result !== 64'd0) begin errors++; $display("FAIL reset o_alu_result: got %0h exp 0", o_alu_result); end
        checks++; if (o_read_data !== 64'd0) begin errors++; $display("FAIL reset o_read_data: got %0h exp 0", o_read_data); end
        checks++; if (o_sb_empty !== 1'b1) begin errors++; $display("FAIL reset o_sb_empty: got %0b exp 1", o_sb_empty); end
        checks++; if (o_dc_we !== 1'b0) begin errors++; $display("FAIL reset o_dc_we: got %0b exp 0", o_dc_we); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset o_stall: got %0b exp 0", o_stall); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_sb_empty !== 1'b1) begin errors++; $display("FAIL idle state: valid %0b empty %0b exp 0 1", o_valid, o_sb_empty); end
    endtask

    task automatic test_store_sd();
        i_dc_ready = 1'b1;
        drive_store(64'h100, 64'h1122334455667788, 3'd3);
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL sd stall: got %0b exp 0", o_stall); end
        checks++; if (o_dc_we !== 1'b0) begin errors++; $display("FAIL sd dc_we before edge: got %0b exp 0", o_dc_we); end
        tick();
        idle_inputs();
        settle();
        checks++; if (o_dc_we !== 1'b1) begin errors++; $display("FAIL sd dc_we: got %0b exp 1", o_dc_we); end
        checks++; if (o_dc_waddr !== 64'h100) begin errors++; $display("FAIL sd waddr: got %0h exp 100", o_dc_waddr); end
        checks++; if (o_dc_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL sd wdata: got %0h exp 1122334455667788", o_dc_wdata); end
        checks++; if (o_dc_store_type !== 2'd3) begin errors++; $display("FAIL sd type: got %0d exp 3", o_dc_store_type); end
        checks++; if (o_valid !== 1'b1 || o_reg_we !== 1'b0) begin errors++; $display("FAIL sd wb: valid %0b reg_we %0b exp 1 0", o_valid, o_reg_we); end
        tick();
        checks++; if (o_sb_empty !== 1'b1 || o_dc_we !== 1'b0) begin errors++; $display("FAIL sd drained: empty %0b dc_we %0b exp 1 0", o_sb_empty, o_dc_we); end
    endtask

    task automatic test_full_wrap();
        logic [63:0] exp_addr [3];
        i_dc_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_store(64'h400 + 64'(8 * k), 64'hA0 + 64'(k), 3'd2);
            settle();
            checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL fill stall store %0d: got %0b exp 0", k, o_stall); end
            tick();
        end
        drive_store(64'h420, 64'hA4, 3'd2);
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL full stall: got %0b exp 1", o_stall); end
        tick();
        checks++; if (o_stall !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL full hold: stall %0b valid %0b exp 1 0", o_stall, o_valid); end
        checks++; if (o_dc_waddr !== 64'h400) begin errors++; $display("FAIL full head: got %0h exp 400", o_dc_waddr); end
        i_dc_ready = 1'b1;
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL full pop same cycle stall: got %0b exp 1", o_stall); end
        tick();
        checks++; if (o_stall !== 1'b0 || o_dc_waddr !== 64'h408) begin errors++; $display("FAIL after pop: stall %0b head %0h exp 0 408", o_stall, o_dc_waddr); end
        tick();
        idle_inputs();
        exp_addr[0] = 64'h410;
        exp_addr[1] = 64'h418;
        exp_addr[2] = 64'h420;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (o_dc_we !== 1'b1 || o_dc_waddr !== exp_addr[k]) begin errors++; $display("FAIL drain order %0d: we %0b addr %0h exp 1 %0h", k, o_dc_we, o_dc_waddr, exp_addr[k]); end
            tick();
        end
        checks++; if (o_sb_empty !== 1'b1) begin errors++; $display("FAIL wrap drained: empty %0b exp 1", o_sb_empty); end
    endtask

    task automatic test_load_conflict();
        i_dc_ready = 1'b0;
        i_dc_hit   = 1'b1;
        drive_store(64'h208, 64'hDEADBEEF, 3'd2);
        tick();
        idle_inputs();
        i_dc_rdata = 64'h0123456789ABCDEF;
        drive_load(64'h210, 3'd3, 5'd7);
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL other dword stall: got %0b exp 0", o_stall); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_read_data !== 64'h0123456789ABCDEF || o_rd_addr !== 5'd7) begin errors++; $display("FAIL other dword wb: valid %0b data %0h rd %0d exp 1 0123456789abcdef 7", o_valid, o_read_data, o_rd_addr); end
        i_dc_rdata = 64'h8765432100000000;
        drive_load(64'h20C, 3'd2, 5'd9);
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL conflict stall: got %0b exp 1", o_stall); end
        checks++; if (o_dc_raddr !== 64'h20C) begin errors++; $display("FAIL raddr: got %0h exp 20c", o_dc_raddr); end
        checks++; if (o_dc_wdata !== 64'hDEADBEEF || o_dc_store_type !== 2'd2) begin errors++; $display("FAIL conflict head: data %0h type %0d exp deadbeef 2", o_dc_wdata, o_dc_store_type); end
        tick();
        checks++; if (o_stall !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL conflict hold: stall %0b valid %0b exp 1 0", o_stall, o_valid); end
        i_dc_ready = 1'b1;
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL conflict popping stall: got %0b exp 1", o_stall); end
        tick();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL conflict released: got %0b exp 0", o_stall); end
        tick();
        idle_inputs();
        checks++; if (o_valid !== 1'b1 || o_reg_we !== 1'b1 || o_read_data !== 64'hFFFFFFFF87654321 || o_rd_addr !== 5'd9) begin errors++; $display("FAIL conflict wb: valid %0b we %0b data %0h rd %0d exp 1 1 ffffffff87654321 9", o_valid, o_reg_we, o_read_data, o_rd_addr); end
        checks++; if (o_alu_result !== 64'h20C || o_result_src !== 3'd1) begin errors++; $display("FAIL conflict wb fields: alu %0h src %0d exp 20c 1", o_alu_result, o_result_src); end
    endtask

    task automatic test_load_extend();
        i_dc_hit   = 1'b1;
        i_dc_rdata = 64'h00000000000080FF;
        drive_load(64'h301, 3'b000, 5'd3);
        tick();
        checks++; if (o_read_data !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb: got %0h exp ffffffffffffff80", o_read_data); end
        drive_load(64'h301, 3'b100, 5'd3);
        tick();
        checks++; if (o_read_data !== 64'h80) begin errors++; $display("FAIL lbu: got %0h exp 80", o_read_data); end
        drive_load(64'h300, 3'b001, 5'd3);
        tick();
        checks++; if (o_read_data !== 64'hFFFFFFFFFFFF80FF) begin errors++; $display("FAIL lh: got %0h exp ffffffffffff80ff", o_read_data); end
        drive_load(64'h300, 3'b101, 5'd3);
        tick();
        idle_inputs();
        checks++; if (o_read_data !== 64'h80FF) begin errors++; $display("FAIL lhu: got %0h exp 80ff", o_read_data); end
    endtask

    task automatic test_miss();
        i_dc_hit   = 1'b0;
        i_dc_rdata = 64'hCAFEF00D12345678;
        drive_load(64'h500, 3'd3, 5'd12);
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL miss stall %0d: got %0b exp 1", k, o_stall); end
            tick();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL miss bubble %0d: got %0b exp 0", k, o_valid); end
        end
        i_dc_hit = 1'b1;
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL miss refill stall: got %0b exp 0", o_stall); end
        tick();
        idle_inputs();
        checks++; if (o_valid !== 1'b1 || o_read_data !== 64'hCAFEF00D12345678 || o_rd_addr !== 5'd12) begin errors++; $display("FAIL miss wb: valid %0b data %0h rd %0d exp 1 cafef00d12345678 12", o_valid, o_read_data, o_rd_addr); end
    endtask

    task automatic test_reset_mid_drain();
        i_dc_ready = 1'b0;
        drive_store(64'h600, 64'h1, 3'd3);
        tick();
        drive_store(64'h608, 64'h2, 3'd3);
        tick();
        idle_inputs();
        checks++; if (o_sb_empty !== 1'b0) begin errors++; $display("FAIL pre-reset occupancy: empty %0b exp 0", o_sb_empty); end
        i_arst = 1'b1;
        tick();
        i_arst = 1'b0;
        settle();
        checks++; if (o_sb_empty !== 1'b1 || o_dc_we !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL reset mid-drain: empty %0b dc_we %0b valid %0b exp 1 0 0", o_sb_empty, o_dc_we, o_valid); end
    endtask

    initial begin
        i_arst     = 1'b1;
        i_dc_rdata = 64'd0;
        i_dc_hit   = 1'b1;
        i_dc_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_store_sd();
        test_full_wrap();
        test_load_conflict();
        test_load_extend();
        test_miss();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage_sb.md
# memory_stage_sb

Parametrised memory stage with a store buffer. Stores are queued in a SB_DEPTH-entry FIFO and drained into the data cache write port whenever the cache accepts them. Loads read the cache directly, but stall while the buffer holds an older store to the same doubleword. The block sits between the execute pipeline register and writeback, and ends in its own memory/writeback pipeline register with bubble insertion.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width (doubleword granularity = DATA_WIDTH/8 bytes)
- REG_ADDR_W, 5, register address width
- SB_DEPTH, 4, store buffer entries; power of two, ≥2

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_arst  in  1  reset; **synchronous, active-high** (name kept for consistency)
- i_valid  in  1  instruction present in stage
- i_mem_we  in  1  store
- i_mem_re  in  1  load
- i_func3  in  3  load/store type; [1:0] = size, [2] = unsigned load
- i_alu_result  in  ADDR_WIDTH  effective address / ALU result
- i_write_data  in  DATA_WIDTH  store data (right-aligned)
- i_rd_addr  in  REG_ADDR_W  destination register
- i_reg_we  in  1  register write enable
- i_result_src  in  3  writeback select
- o_stall  out  1  hold upstream stages this cycle
- o_dc_raddr  out  ADDR_WIDTH  cache read address (= i_alu_result)
- i_dc_rdata  in  DATA_WIDTH  cache read doubleword
- i_dc_hit  in  1  cache read hit
- o_dc_we  out  1  head store presented to cache
- o_dc_waddr  out  ADDR_WIDTH  head store address
- o_dc_wdata  out  DATA_WIDTH  head store data
- o_dc_store_type  out  2  head store size
- i_dc_ready  in  1  cache accepts the presented store this cycle
- o_sb_empty  out  1  buffer empty (for fences)
- o_valid, o_reg_we  out  1  writeback register
- o_rd_addr  out  REG_ADDR_W  writeback register
- o_result_src  out  3  writeback register
- o_alu_result, o_read_data  out  DATA_WIDTH  writeback register

## Operation
- Buffer state: entries {addr, data, type}, head/tail pointers of $clog2(SB_DEPTH) bits (wrap modulo SB_DEPTH), count of $clog2(SB_DEPTH)+1 bits.
- Store accept: i_valid & i_mem_we & count<SB_DEPTH → enqueue at tail.
- Store when count==SB_DEPTH → o_stall=1; no enqueue, even if a pop occurs the same cycle.
- Drain: o_dc_we = (count!=0); o_dc_* driven from head. Pop when o_dc_we & i_dc_ready.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Load conflict: i_valid & i_mem_re and any valid entry has addr[ADDR_WIDTH-1:3] == i_alu_result[ADDR_WIDTH-1:3] → o_stall=1. The match uses registered entries only; an entry popping this cycle still counts.
- Load miss: i_valid & i_mem_re & !i_dc_hit & no conflict → o_stall=1; an external controller refills the cache.
- Load data: extract the byte/half/word/dword from i_dc_rdata at offset i_alu_result[2:0], then sign- or zero-extend per i_func3.
- o_stall is combinational from i_* and registered state. It never depends on i_dc_ready.
- Writeback register:
  - Stalled cycle or !i_valid → loads bubble: o_valid=0, o_reg_we=0; other fields don't-care (hold).
  - Otherwise → captures inputs plus the extracted load data.
- Stores write no register: o_reg_we passes i_reg_we, which is 0 for stores.

## Timing
- Reset (i_arst high at edge): count=0, head=tail=0, o_valid=0, o_reg_we=0, o_rd_addr=0, o_result_src=0, o_alu_result=0, o_read_data=0.
- After reset: o_sb_empty=1, o_dc_we=0. Entry payloads are not reset.
- Reset mid-drain discards all queued stores.
- Store accepted at edge N: visible on o_dc_we from cycle N+1. Minimum store-to-cache latency is 1 cycle.
- Load hit without conflict: data on o_read_data after 1 edge.
- Conflicting load: proceeds the cycle after the last matching entry pops.
- Throughput: 1 store/cycle while i_dc_ready stays high.

## Structure
- Shared package mem_pkg:
  - sb_entry_t struct
  - store-type constants (SB=0, SH=1, SW=2, SD=3)
  - load func3 constants
- Sub-module store_buffer: FIFO, count, and doubleword-match comparator array with output o_match.
- Load alignment reuses the existing load_mux.
- The top level holds the stall logic and the writeback register.

## Test plan
- Reset, then idle: all outputs at reset values; o_sb_empty=1.
- Store SD 0x1122334455667788 to 0x100 with i_dc_ready=1: o_dc_we=1 with addr 0x100 one cycle later; buffer empty after the next edge.
- i_dc_ready=0, four SW stores (SB_DEPTH=4): o_stall=0 for all four. A fifth store gives o_stall=1 until i_dc_ready rises; then entries drain FIFO-ordered; pointer wrap verified.
- Buffered SW 0xDEADBEEF to 0x208, then LW from 0x20C: o_stall=1 until that entry pops. The load then returns the cache data, sign-extended.
- LB from 0x301 with i_dc_rdata=0x...80FF, hit: o_read_data=0xFFFFFFFFFFFFFF80. The same with LBU gives 0x80.
- i_dc_hit=0 on a load: o_stall=1, o_valid=0 each cycle. A hit on the next cycle writes back normally.
